// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - calculator display value types and seven-segment glyph helpers
package calc_pkg;

    localparam int NumDigits = 4;
    localparam int ExpWidth  = 4;

    typedef logic [3:0] bcd_t;

    // significand[NumDigits-1] is the leftmost digit; exponent is the units digit position from the left
    typedef struct packed {
        bcd_t [NumDigits-1:0]  significand;
        logic [ExpWidth-1:0]   exponent;
    } num_t;

    // bit0 = a ... bit6 = g, active-high
    typedef logic [6:0] seg_t;

    localparam seg_t SegBlank = 7'h00;
    localparam seg_t SegDash  = 7'h40;

    function automatic seg_t bcd2seg(input bcd_t digit);
        seg_t seg;
        case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = SegDash;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/display_scan_pkg.sv
// rtl/display_scan_pkg.sv - scan controller state encoding
package display_scan_pkg;

    typedef enum logic {
        ST_DEAD = 1'b0,
        ST_ON   = 1'b1
    } scan_state_t;

endpackage

// File: rtl/display_scan_if.sv
// rtl/display_scan_if.sv - display value input and scanned pin outputs
interface display_scan_if;
    import calc_pkg::*;

    logic                 enable_i;
    num_t                 display_rdata_i;
    seg_t                 seg_o;
    logic                 dp_o;
    logic [NumDigits-1:0] an_o;
    logic                 frame_o;

    modport master (
        output enable_i,
        output display_rdata_i,
        input  seg_o,
        input  dp_o,
        input  an_o,
        input  frame_o
    );

    modport slave (
        input  enable_i,
        input  display_rdata_i,
        output seg_o,
        output dp_o,
        output an_o,
        output frame_o
    );

endinterface

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational BCD to active-high segment pattern with blanking
module seg7_decoder
    import calc_pkg::*;
(
    input  bcd_t digit,
    input  logic blank,
    output seg_t seg
);

    assign seg = blank ? SegBlank : bcd2seg(digit);

endmodule

// File: rtl/display_scan.sv
// rtl/display_scan.sv - multiplexed seven-segment scanner with dead time and per-frame snapshot
// Optional trailing-zero blanking: DISPLAY_SCAN_TRAILING_BLANK_EN
module display_scan
    import calc_pkg::*;
    import display_scan_pkg::*;
#(
    parameter int NumDigits   = calc_pkg::NumDigits,
    parameter int DigitCycles = 1024,
    parameter int DeadCycles  = 16,
    parameter bit ActiveLow   = 1'b1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    display_scan_if.slave  bus
);

    localparam int PW = (DigitCycles > 1) ? $clog2(DigitCycles) : 1;
    localparam int IW = (NumDigits > 1) ? $clog2(NumDigits) : 1;

    localparam logic [PW-1:0] PrescLast = PW'(DigitCycles - 1);
    localparam logic [PW-1:0] DeadLast  = PW'(DeadCycles - 1);
    localparam logic [IW-1:0] IdxLast   = IW'(NumDigits - 1);

    localparam logic [NumDigits-1:0] AnOff  = ActiveLow ? '1 : '0;
    localparam seg_t                 SegOff = ActiveLow ? 7'h7F : 7'h00;
    localparam logic                 DpOff  = ActiveLow;

    scan_state_t    state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic           primed_q;
    logic           snap_take;
    num_t           snap_q;

    logic [NumDigits-1:0] an_q;
    seg_t                 seg_q;
    logic                 dp_q;
    logic                 frame_q;

    // The first edge after reset only takes the snapshot; counters start moving on the next one
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        presc_d   = presc_q;
        snap_take = 1'b0;
        if (!primed_q) begin
            snap_take = 1'b1;
        end else begin
            presc_d = (presc_q == PrescLast) ? '0 : presc_q + 1'b1;
            case (state_q)
                ST_DEAD: begin
                    if (presc_q == DeadLast) state_d = ST_ON;
                end
                ST_ON: begin
                    if (presc_q == PrescLast) begin
                        state_d = ST_DEAD;
                        if (idx_q == IdxLast) begin
                            idx_d     = '0;
                            snap_take = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: state_d = ST_DEAD;
            endcase
        end
    end

    bcd_t                 phys [NumDigits];
    logic [NumDigits-1:0] digit_nz;
    logic [NumDigits-1:0] lead_or;
    logic [NumDigits-1:0] trail_or;
    logic [NumDigits-1:0] is_units;
    logic [NumDigits-1:0] before_units;
    logic [NumDigits-1:0] after_units;
    logic [NumDigits-1:0] frac_hit;

    // Per-physical-digit classification; k = 0 is the leftmost position
    for (genvar g = 0; g < NumDigits; g++) begin : g_class
        assign phys[g]         = snap_q.significand[NumDigits-1-g];
        assign digit_nz[g]     = (phys[g] != 4'd0);
        assign lead_or[g]      = |digit_nz[g:0];
        assign trail_or[g]     = |digit_nz[NumDigits-1:g];
        assign is_units[g]     = (snap_q.exponent == ExpWidth'(g));
        assign before_units[g] = (ExpWidth'(g) < snap_q.exponent);
        assign after_units[g]  = (ExpWidth'(g) > snap_q.exponent);
        assign frac_hit[g]     = after_units[g] & digit_nz[g];
    end

    logic overflow;
    logic blank;
    logic dp_on;
    bcd_t dec_digit;
    seg_t dec_seg;

    always_comb begin
        overflow  = (snap_q.exponent >= ExpWidth'(NumDigits));
        dec_digit = overflow ? 4'hF : phys[idx_d];
        blank     = !overflow && before_units[idx_d] && !lead_or[idx_d];
        dp_on     = !overflow && is_units[idx_d];
`ifdef DISPLAY_SCAN_TRAILING_BLANK_EN
        if (!overflow && after_units[idx_d] && !trail_or[idx_d]) blank = 1'b1;
        if (!(|frac_hit)) dp_on = 1'b0;
`endif
    end

    seg7_decoder u_dec (
        .digit (dec_digit),
        .blank (blank),
        .seg   (dec_seg)
    );

    logic [NumDigits-1:0] an_act;
    seg_t                 seg_act;
    logic                 dp_act;

    always_comb begin
        an_act  = '0;
        seg_act = SegBlank;
        dp_act  = 1'b0;
        if (state_d == ST_ON) begin
            if (bus.enable_i) an_act = NumDigits'(1) << idx_d;
            seg_act = dec_seg;
            dp_act  = dp_on;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_DEAD;
            idx_q    <= '0;
            presc_q  <= '0;
            primed_q <= 1'b0;
            snap_q   <= '0;
            an_q     <= AnOff;
            seg_q    <= SegOff;
            dp_q     <= DpOff;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            presc_q  <= presc_d;
            primed_q <= 1'b1;
            if (snap_take) snap_q <= bus.display_rdata_i;
            an_q     <= ActiveLow ? ~an_act  : an_act;
            seg_q    <= ActiveLow ? ~seg_act : seg_act;
            dp_q     <= ActiveLow ? ~dp_act  : dp_act;
            frame_q  <= snap_take;
        end
    end

    assign bus.an_o    = an_q;
    assign bus.seg_o   = seg_q;
    assign bus.dp_o    = dp_q;
    assign bus.frame_o = frame_q;

endmodule
